switch_conditioner: RTL and testbench
=====================================

SWITCH_CONDITIONER -- requirements
Module: switch_conditioner

Interface
REQ-001 Parameter c_DEBOUNCE_LIMIT, default 250, number of consecutive clocks a synchronized input must differ from its debounced state before that state is updated (10 ms at the 25 kHz system clock); legal range 2 to 2^32-1.
REQ-002 Parameter c_ENABLE_AT_RESET, default 1'b1, value loaded into o_enable by reset.
REQ-003 i_clock  input  1  system clock; all state updates on its rising edge.
REQ-004 i_reset  input  1  synchronous, active-high reset.
REQ-005 i_switch_1  input  1  raw, asynchronous, bouncing frequency-select switch, MSB.
REQ-006 i_switch_2  input  1  raw, asynchronous, bouncing frequency-select switch, LSB.
REQ-007 i_button  input  1  raw, asynchronous, bouncing momentary push-button, 1 = pressed.
REQ-008 o_switch_1  output  1  debounced i_switch_1, registered.
REQ-009 o_switch_2  output  1  debounced i_switch_2, registered.
REQ-010 o_enable  output  1  LED enable level, toggled by each debounced button press, registered.
REQ-011 o_sel_changed  output  1  single-cycle pulse when {o_switch_1,o_switch_2} changes value.

Function
REQ-012 Each raw input SHALL pass through its own 2-flop synchronizer before any other logic; no raw input SHALL reach an output or counter directly.
REQ-013 Each of the three channels SHALL have an independent 32-bit debounce counter and a debounced-state register.
REQ-014 Per channel, each clock: synchronized value equal to debounced state -> counter cleared to 0.
REQ-015 Per channel, each clock: values differ and counter /= c_DEBOUNCE_LIMIT-1 -> counter incremented by 1.
REQ-016 Per channel, each clock: values differ and counter == c_DEBOUNCE_LIMIT-1 -> debounced state takes the synchronized value and counter is cleared to 0.
REQ-017 Any single cycle of agreement during a pending change SHALL restart that channel's count from 0; a glitch shorter than c_DEBOUNCE_LIMIT synchronized cycles SHALL never change an output.
REQ-018 Latency: a raw input held stable after a change SHALL be reflected on its debounced state exactly c_DEBOUNCE_LIMIT+2 rising edges after the first edge that samples the new value.
REQ-019 Counters SHALL never exceed c_DEBOUNCE_LIMIT-1, so they cannot wrap.
REQ-020 o_switch_1 and o_switch_2 SHALL be the debounced states of their channels.
REQ-021 The button channel SHALL drive a rising-edge detector: debounced button 0->1 SHALL invert o_enable on the following edge (1 clock after the debounced transition).
REQ-022 A debounced button release (1->0) SHALL not change o_enable; holding the button pressed SHALL toggle o_enable exactly once.
REQ-023 o_sel_changed SHALL be 1 for exactly one clock, on the clock after either debounced switch state changes.
REQ-024 Both switches changing debounced state on the same edge SHALL produce a single one-cycle pulse, not two.
REQ-025 Switch changes on consecutive edges SHALL produce one pulse per changing edge; the pulse SHALL not be stretched or merged.
REQ-026 Switch and button channels SHALL be fully independent; simultaneous events on all channels SHALL be handled in the same cycle without priority.

Reset
REQ-027 While i_reset = 1 at a rising edge: synchronizer flops, debounce counters, debounced states and edge-detect history SHALL be cleared to 0.
REQ-028 Reset values: o_switch_1 = 0, o_switch_2 = 0, o_sel_changed = 0, o_enable = c_ENABLE_AT_RESET.
REQ-029 Reset asserted mid-debounce SHALL discard the pending count; debouncing SHALL restart from 0 after release.
REQ-030 The first debounced state change after reset SHALL produce o_sel_changed and button edges exactly as in normal operation; the reset itself SHALL generate no pulse and no enable toggle.

Verification (c_DEBOUNCE_LIMIT = 4, c_ENABLE_AT_RESET = 1)
REQ-031 Reset, then i_switch_1 0->1 held -> o_switch_1 rises on the 6th edge; o_sel_changed = 1 for one clock on the 7th edge only.
REQ-032 i_switch_2 pulses high for 3 clocks, repeated with 1-clock lows -> o_switch_2 stays 0 and o_sel_changed never asserts.
REQ-033 i_switch_1 and i_switch_2 both 0->1 on the same edge, held -> both outputs rise on the same edge; exactly one o_sel_changed pulse.
REQ-034 i_button held pressed for 20 clocks, then released -> o_enable goes 1->0 once, 7 edges after the press, and stays 0 through the release; a second press returns it to 1.
REQ-035 i_switch_1 raised, then i_reset asserted 2 clocks before the expected update -> o_switch_1 stays 0; after release o_switch_1 rises 6 edges later with one o_sel_changed pulse.
REQ-036 Scoreboard over random bouncing stimulus -> every output change is preceded by at least 4 consecutive matching synchronized samples; counters never exceed 3.

Source files
------------

// File: rtl/switch_conditioner_if.sv
// ----------------------------------------------------------------------------
// switch_conditioner_if
// Bundle of the switch/button signals exchanged with switch_conditioner.
//
// Signals:
//   i_switch_1    raw bouncing frequency-select switch, MSB (into conditioner)
//   i_switch_2    raw bouncing frequency-select switch, LSB (into conditioner)
//   i_button      raw bouncing momentary push-button, 1 = pressed
//   o_switch_1    debounced i_switch_1
//   o_switch_2    debounced i_switch_2
//   o_enable      LED enable level, toggled by each debounced press
//   o_sel_changed one-cycle pulse after {o_switch_1,o_switch_2} changes
//
// Modports:
//   master  drives the raw inputs and observes the conditioned outputs
//   slave   the conditioner itself
// ----------------------------------------------------------------------------
interface switch_conditioner_if;
    logic i_switch_1;
    logic i_switch_2;
    logic i_button;
    logic o_switch_1;
    logic o_switch_2;
    logic o_enable;
    logic o_sel_changed;

    modport master (
        output i_switch_1,
        output i_switch_2,
        output i_button,
        input  o_switch_1,
        input  o_switch_2,
        input  o_enable,
        input  o_sel_changed
    );

    modport slave (
        input  i_switch_1,
        input  i_switch_2,
        input  i_button,
        output o_switch_1,
        output o_switch_2,
        output o_enable,
        output o_sel_changed
    );
endinterface

// File: rtl/switch_conditioner.sv
// ----------------------------------------------------------------------------
// switch_conditioner
// Synchronizes and debounces two frequency-select switches and a push-button.
// The debounced switches are output directly plus a one-cycle "selection
// changed" pulse; each debounced button press toggles an LED enable level.
//
// Parameters:
//   c_DEBOUNCE_LIMIT   consecutive differing synchronized samples required
//                      before a debounced state flips (2 .. 2^32-1)
//   c_ENABLE_AT_RESET  o_enable value after reset
//
// Ports:
//   i_clock   system clock, rising edge
//   i_reset   synchronous active-high reset
//   io_bus    switch_conditioner_if.slave (raw inputs, conditioned outputs)
// ----------------------------------------------------------------------------
module switch_conditioner #(
    parameter int unsigned c_DEBOUNCE_LIMIT  = 250,
    parameter logic        c_ENABLE_AT_RESET = 1'b1
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    switch_conditioner_if.slave  io_bus
);

    // Channel indices into the per-channel vectors.
    localparam int c_CH_SWITCH_2 = 0;
    localparam int c_CH_SWITCH_1 = 1;
    localparam int c_CH_BUTTON   = 2;
    localparam int c_CHANNELS    = 3;

    // Terminal count: a state flips on the sample that finds the counter here.
    localparam logic [31:0] c_COUNT_MAX = c_DEBOUNCE_LIMIT - 32'd1;

    logic [c_CHANNELS-1:0] w_raw;
    logic [c_CHANNELS-1:0] r_sync_1;
    logic [c_CHANNELS-1:0] r_sync_2;
    logic [c_CHANNELS-1:0] w_debounced;
    logic [1:0]            w_sel;
    logic [1:0]            r_sel_prev;
    logic                  r_button_prev;
    logic                  w_button_rise;
    logic                  r_sel_changed;
    logic                  r_enable;

    assign w_raw[c_CH_SWITCH_2] = io_bus.i_switch_2;
    assign w_raw[c_CH_SWITCH_1] = io_bus.i_switch_1;
    assign w_raw[c_CH_BUTTON]   = io_bus.i_button;

    // Two-flop synchronizer; nothing downstream ever looks at w_raw or r_sync_1.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, exactly like hardware.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sync_1 <= '0;
            r_sync_2 <= '0;
        end else begin
            r_sync_1 <= w_raw;
            r_sync_2 <= r_sync_1;
        end
    end

    // Independent debouncer per channel. Any sample that agrees with the
    // current state restarts the count, so only an unbroken run of
    // c_DEBOUNCE_LIMIT differing samples can flip the state. The counter is
    // cleared on the flip and therefore never passes c_COUNT_MAX.
    for (genvar g_ch = 0; g_ch < c_CHANNELS; g_ch++) begin : g_debounce
        logic [31:0] r_count;
        logic        r_state;

        always_ff @(posedge i_clock) begin
            if (i_reset) begin
                r_count <= '0;
                r_state <= 1'b0;
            end else if (r_sync_2[g_ch] == r_state) begin
                r_count <= '0;
            end else if (r_count == c_COUNT_MAX) begin
                r_state <= r_sync_2[g_ch];
                r_count <= '0;
            end else begin
                r_count <= r_count + 32'd1;
            end
        end

        assign w_debounced[g_ch] = r_state;
    end

    assign w_sel         = {w_debounced[c_CH_SWITCH_1], w_debounced[c_CH_SWITCH_2]};
    assign w_button_rise = w_debounced[c_CH_BUTTON] & ~r_button_prev;

    // Edge detection one clock behind the debounced states. History resets to
    // the same zero the debounced states reset to, so reset itself produces
    // neither a selection pulse nor an enable toggle. Comparing the 2-bit
    // selection as a whole merges simultaneous switch flips into one pulse.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sel_prev    <= '0;
            r_button_prev <= 1'b0;
            r_sel_changed <= 1'b0;
            r_enable      <= c_ENABLE_AT_RESET;
        end else begin
            r_sel_prev    <= w_sel;
            r_button_prev <= w_debounced[c_CH_BUTTON];
            r_sel_changed <= (w_sel != r_sel_prev);
            if (w_button_rise) begin
                r_enable <= ~r_enable;
            end
        end
    end

    assign io_bus.o_switch_1    = w_debounced[c_CH_SWITCH_1];
    assign io_bus.o_switch_2    = w_debounced[c_CH_SWITCH_2];
    assign io_bus.o_enable      = r_enable;
    assign io_bus.o_sel_changed = r_sel_changed;

endmodule

// File: tb/tb_switch_conditioner.sv
// ----------------------------------------------------------------------------
// tb_switch_conditioner
// Drives switch_conditioner (c_DEBOUNCE_LIMIT = 4) through directed scenarios
// and a stretch of random bouncing. A behavioural model predicts the outputs
// after every edge; the prediction is queued when stimulus is applied and
// popped when the edge has produced the DUT output.
// Observation vector layout: {o_switch_1, o_switch_2, o_enable, o_sel_changed}.
// Raw stimulus vector layout: {i_button, i_switch_1, i_switch_2}.
// ----------------------------------------------------------------------------
module tb_switch_conditioner;

    localparam int unsigned c_LIMIT = 4;

    logic i_clock = 1'b0;
    logic i_reset = 1'b1;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Scoreboard of predicted observation vectors.
    logic [3:0] exp_q[$];

    // Behavioural model state.
    logic [2:0]  m_pipe[$];     // raw samples still in flight through the synchronizer
    int unsigned m_run[3];      // length of the current run of differing samples
    logic [2:0]  m_db;          // predicted debounced states
    logic        m_sel_flag;    // a switch flipped on the previous edge
    logic        m_rise_flag;   // button went 0->1 on the previous edge
    logic        m_en;
    logic        m_pulse;

    logic [3:0] obs;
    int         pulses;

    switch_conditioner_if bus();

    switch_conditioner #(
        .c_DEBOUNCE_LIMIT  (c_LIMIT),
        .c_ENABLE_AT_RESET (1'b1)
    ) dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .io_bus  (bus)
    );

    always #5 i_clock = ~i_clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance the model by one rising edge with the given raw inputs.
    task automatic model_edge(input logic [2:0] raw, input logic rst);
        logic [2:0] sample;
        logic [2:0] old_db;
        if (rst) begin
            m_pipe.delete();
            m_pipe.push_back(3'b000);
            m_pipe.push_back(3'b000);
            for (int ch = 0; ch < 3; ch++) m_run[ch] = 0;
            m_db        = 3'b000;
            m_sel_flag  = 1'b0;
            m_rise_flag = 1'b0;
            m_en        = 1'b1;
            m_pulse     = 1'b0;
        end else begin
            m_pulse = m_sel_flag;
            if (m_rise_flag) m_en = ~m_en;
            sample = m_pipe.pop_front();
            m_pipe.push_back(raw);
            old_db = m_db;
            for (int ch = 0; ch < 3; ch++) begin
                if (sample[ch] !== m_db[ch]) begin
                    m_run[ch]++;
                    if (m_run[ch] == c_LIMIT) begin
                        m_db[ch]  = sample[ch];
                        m_run[ch] = 0;
                    end
                end else begin
                    m_run[ch] = 0;
                end
            end
            m_sel_flag  = (m_db[1:0] != old_db[1:0]);
            m_rise_flag = m_db[2] & ~old_db[2];
        end
    endtask

    // Apply inputs, predict, take one edge, compare against the prediction.
    task automatic step(input logic [2:0] raw, input logic rst, output logic [3:0] observed);
        logic [3:0] expected;
        @(negedge i_clock);
        bus.i_button   = raw[2];
        bus.i_switch_1 = raw[1];
        bus.i_switch_2 = raw[0];
        i_reset        = rst;
        model_edge(raw, rst);
        exp_q.push_back({m_db[1], m_db[0], m_en, m_pulse});
        @(posedge i_clock);
        #1;
        observed = {bus.o_switch_1, bus.o_switch_2, bus.o_enable, bus.o_sel_changed};
        expected = exp_q.pop_front();
        check("scoreboard", {28'd0, observed}, {28'd0, expected});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] raw;
        int         hold[3];

        bus.i_switch_1 = 1'b0;
        bus.i_switch_2 = 1'b0;
        bus.i_button   = 1'b0;

        // Reset state.
        step(3'b000, 1'b1, obs);
        step(3'b000, 1'b1, obs);
        check("reset_state", {28'd0, obs}, 32'h2);

        // Switch 1 rises; debounced on edge 6, selection pulse on edge 7 only.
        for (int k = 1; k <= 8; k++) begin
            step(3'b010, 1'b0, obs);
            check("sw1_level", {31'd0, obs[3]}, {31'd0, k >= 6});
            check("sw1_pulse", {31'd0, obs[0]}, {31'd0, k == 7});
        end

        // Switch 2 glitches: 3 high, 1 low, repeated; never reaches the limit.
        for (int p = 0; p < 4; p++) begin
            for (int j = 0; j < 4; j++) begin
                step({2'b01, j < 3}, 1'b0, obs);
                check("glitch_sw2", {31'd0, obs[2]}, 32'd0);
                check("glitch_pulse", {31'd0, obs[0]}, 32'd0);
            end
        end
        for (int k = 0; k < 4; k++) step(3'b010, 1'b0, obs);

        // Both switches rise together: single pulse.
        step(3'b000, 1'b1, obs);
        step(3'b000, 1'b1, obs);
        check("reset_state_2", {28'd0, obs}, 32'h2);
        pulses = 0;
        for (int k = 1; k <= 10; k++) begin
            step(3'b011, 1'b0, obs);
            check("both_sw1", {31'd0, obs[3]}, {31'd0, k >= 6});
            check("both_sw2", {31'd0, obs[2]}, {31'd0, k >= 6});
            pulses += int'(obs[0]);
        end
        check("both_single_pulse", pulses, 32'd1);

        // Reset two clocks before the pending switch 1 update discards it.
        step(3'b000, 1'b1, obs);
        step(3'b000, 1'b1, obs);
        for (int k = 1; k <= 4; k++) begin
            step(3'b010, 1'b0, obs);
            check("pend_sw1", {31'd0, obs[3]}, 32'd0);
        end
        step(3'b010, 1'b1, obs);
        step(3'b010, 1'b1, obs);
        check("mid_reset_state", {28'd0, obs}, 32'h2);
        for (int k = 1; k <= 8; k++) begin
            step(3'b010, 1'b0, obs);
            check("post_reset_sw1", {31'd0, obs[3]}, {31'd0, k >= 6});
            check("post_reset_pulse", {31'd0, obs[0]}, {31'd0, k == 7});
        end

        // Button held 20 clocks: one toggle 7 edges after press, none on release.
        for (int k = 1; k <= 20; k++) begin
            step(3'b110, 1'b0, obs);
            check("press1_enable", {31'd0, obs[1]}, {31'd0, k < 7});
        end
        for (int k = 1; k <= 10; k++) begin
            step(3'b010, 1'b0, obs);
            check("release_enable", {31'd0, obs[1]}, 32'd0);
        end
        for (int k = 1; k <= 10; k++) begin
            step(3'b110, 1'b0, obs);
            check("press2_enable", {31'd0, obs[1]}, {31'd0, k >= 7});
        end
        for (int k = 1; k <= 8; k++) step(3'b010, 1'b0, obs);

        // Random bouncing on all channels, with occasional resets.
        raw = 3'b010;
        for (int ch = 0; ch < 3; ch++) hold[ch] = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int ch = 0; ch < 3; ch++) begin
                if (hold[ch] == 0) begin
                    raw[ch]  = 1'($urandom_range(0, 1));
                    hold[ch] = int'($urandom_range(1, 7));
                end
                hold[ch]--;
            end
            step(raw, ($urandom_range(0, 499) == 0), obs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
